// File: rtl/pipe_skid_register.sv
// Two-entry skid stage with registered valid/ready on both sides.
// out_data comes straight from the main register; the skid register catches the overflow beat.
module pipe_skid_register #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    state_t           w_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_nxt          = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_nxt        = ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_nxt     = FULL;
                    w_ld_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_nxt          = ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: w_nxt = EMPTY;
        endcase
        // Flush wins; any beat accepted on this edge is dropped.
        if (flush) begin
            w_nxt          = EMPTY;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_main      <= INIT;
            r_skid      <= INIT;
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= (w_nxt != FULL);
            r_out_valid <= (w_nxt == ONE) || (w_nxt == FULL);
            r_occ       <= w_nxt;
            if (flush) begin
                r_main <= INIT;
                r_skid <= INIT;
            end else begin
                if (w_ld_main_in)   r_main <= in_data;
                if (w_ld_main_skid) r_main <= r_skid;
                if (w_ld_skid)      r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occ;

endmodule

// File: doc/pipe_skid_register.md
Name: pipe_skid_register

Overview:
- Two-entry registered pipeline stage with valid/ready handshake on both sides; drop-in replacement for a plain enable register wherever a pipeline boundary needs back-pressure.
- Sits directly upstream of the core's plain data registers, which capture on out_valid & out_ready. It feeds those registers so that no input beat is lost when downstream stalls.
- All outputs are registered, so the ready path is timing-isolated: full throughput, zero combinational in-to-out paths.

Parameters:
- WIDTH, 32, data width in bits.
- INIT, 0, value loaded into both data registers on reset and on flush.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous discard of all held data; active-high.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle; registered.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid beat; registered.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_data  output  WIDTH  payload, driven directly from the main register.
- occupancy  output  2  number of held beats, 0..2.

Behaviour:
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
- Storage: main register M, which drives out_data, and skid register S.
- States: EMPTY (occupancy 0), ONE (M valid), FULL (M and S valid).
- Reset (reset = 0, takes effect immediately, no clock required):
  - state EMPTY, out_valid = 0, in_ready = 1, occupancy = 0.
  - M = INIT, S = INIT.
- Reset release: the first edge with reset = 1 behaves as normal EMPTY operation.
- Derived outputs:
  - in_ready = 1 in EMPTY and ONE; 0 in FULL. It is registered from next-state, not from out_ready.
  - out_valid = 1 in ONE and FULL.
- Transitions, evaluated on the clock edge with flush = 0:
  - EMPTY: in_xfer -> ONE, M <= in_data. Otherwise stay.
  - ONE, in_xfer & out_xfer -> ONE, M <= in_data (back-to-back, 1 beat/cycle).
  - ONE, in_xfer only -> FULL, S <= in_data, M held.
  - ONE, out_xfer only -> EMPTY. M keeps its old value (don't-care, not cleared).
  - ONE, neither -> hold.
  - FULL: in_xfer is impossible because in_ready = 0.
  - FULL, out_xfer -> ONE, M <= S.
  - FULL, otherwise -> hold.
- Latency: a beat accepted at edge N is presented with out_valid = 1 after edge N. Minimum latency is 1 cycle.
- Ordering: strict FIFO; the S beat is always older than any later input.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid hold unchanged.
- Flush (flush = 1 at an edge, reset = 1):
  - Next state is EMPTY, with M and S <= INIT.
  - An in_xfer on the same edge is discarded. Upstream saw in_ready = 1, so the beat counts as consumed and is dropped.
  - An out_xfer on the same edge completes normally; downstream owns that beat.
  - Flush has priority over every transition.
- Reset mid-operation: held beats are lost and no partial beat is presented. After release, in_ready = 1 and out_valid = 0.
- Invalid state encodings: recover to EMPTY on the next edge.
- occupancy equals the state encoding (0/1/2) and is registered.

Test Plan:
- Reset: hold reset = 0, toggle in_valid = 1, in_data = 0xDEADBEEF -> out_valid = 0, in_ready = 1, out_data = 0x00000000, occupancy = 0. Then release -> one edge later out_valid = 1, out_data = 0xDEADBEEF.
- Streaming: out_ready = 1, drive 0x1, 0x2, 0x3, 0x4 on consecutive cycles -> out_data shows 0x1..0x4 on consecutive cycles, one cycle late, occupancy stays 1, in_ready never drops.
- Back-pressure: out_ready = 0, push 0xA then 0xB -> occupancy 2, in_ready = 0, out_data = 0xA held stable. Then out_ready = 1 for 2 cycles -> 0xA then 0xB delivered, in_ready = 1 again, occupancy 0.
- Flush while FULL: in FULL with 0xA/0xB, assert flush one cycle -> next cycle occupancy 0, out_valid = 0, out_data = INIT, in_ready = 1. Neither 0xB nor the 0xA beat reappears.
- Flush with simultaneous in_xfer and out_xfer in ONE: M = 0x5, in_data = 0x6, out_ready = 1, flush = 1 -> 0x5 is counted as delivered, 0x6 is dropped, state EMPTY.
- Async reset mid-stall: FULL, pull reset low between clock edges -> out_valid falls without waiting for an edge, occupancy = 0. After release, push 0x7 -> out_data = 0x7, no stale 0xA or 0xB.
